// File: rtl/hb_pwm_dt_multi.sv
// Multi-channel half-bridge PWM: shared edge-aligned carrier, double-buffered duty,
// per-channel dead-time FSM and a periodic interrupt square wave.
module hb_pwm_dt_multi #(
  parameter int CH       = 2,
  parameter int DW       = 10,
  parameter int PERIOD   = 600,
  parameter int DEADTIME = 20,
  parameter int INT_DIV  = 10,
  parameter int INT_HIGH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [CH*DW-1:0] d,
  output logic [CH-1:0]    s,
  output logic [CH-1:0]    nots,
  output logic             clk_int,
  output logic             period_start
);

  localparam int CW = $clog2(PERIOD);
  localparam int SW = DW + 1;
  localparam int IW = $clog2(INT_DIV);
  localparam int TW = $clog2(DEADTIME + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OFF    = 3'd1,
    DT_ON  = 3'd2,
    ON     = 3'd3,
    DT_OFF = 3'd4
  } state_t;

  logic [CW-1:0] cnt_r;
  logic [IW-1:0] int_cnt_r;
  logic [IW-1:0] int_nxt_s;
  logic          wrap_s;
  logic [SW-1:0] shadow_r    [CH];
  state_t        state_r     [CH];
  state_t        state_nxt_s [CH];
  logic [TW-1:0] dt_r        [CH];
  logic [TW-1:0] dt_nxt_s    [CH];
  logic [CH-1:0] ref_s;

  // Shadow is one bit wider than d so that a full-period duty is representable.
  function automatic logic [SW-1:0] sat_duty(input logic [DW-1:0] w);
    if ({1'b0, w} > SW'(PERIOD)) begin
      return SW'(PERIOD);
    end else begin
      return {1'b0, w};
    end
  endfunction

  // Carrier wrap detection and interrupt counter next value.
  always_comb begin
    wrap_s    = (cnt_r == CW'(PERIOD - 1));
    int_nxt_s = int_cnt_r;
    if (period_start) begin
      if (int_cnt_r == IW'(INT_DIV - 1)) begin
        int_nxt_s = '0;
      end else begin
        int_nxt_s = int_cnt_r + IW'(1);
      end
    end else begin
      int_nxt_s = int_cnt_r;
    end
  end

  // Carrier counter, period strobe and interrupt square wave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= '0;
      int_cnt_r    <= '0;
      clk_int      <= 1'b0;
      period_start <= 1'b0;
    end else if (!ce) begin
      cnt_r        <= '0;
      int_cnt_r    <= '0;
      clk_int      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      cnt_r        <= wrap_s ? '0 : cnt_r + CW'(1);
      period_start <= wrap_s;
      int_cnt_r    <= int_nxt_s;
      clk_int      <= (int_nxt_s < IW'(INT_HIGH));
    end
  end

  // Duty shadows survive ce=0 and only reload at the carrier start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        shadow_r[i] <= '0;
      end
    end else if (ce && (cnt_r == '0)) begin
      for (int i = 0; i < CH; i++) begin
        shadow_r[i] <= sat_duty(d[i*DW +: DW]);
      end
    end
  end

  // On-request per channel and dead-time FSM next state.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      ref_s[i]       = (SW'(cnt_r) < shadow_r[i]);
      state_nxt_s[i] = state_r[i];
      dt_nxt_s[i]    = dt_r[i];
      case (state_r[i])
        IDLE: begin
          state_nxt_s[i] = OFF;
        end
        OFF: begin
          if (ref_s[i]) begin
            state_nxt_s[i] = DT_ON;
            dt_nxt_s[i]    = '0;
          end else begin
            state_nxt_s[i] = OFF;
          end
        end
        DT_ON: begin
          if (!ref_s[i]) begin
            state_nxt_s[i] = OFF;
          end else if (dt_r[i] == TW'(DEADTIME - 1)) begin
            state_nxt_s[i] = ON;
          end else begin
            dt_nxt_s[i] = dt_r[i] + TW'(1);
          end
        end
        ON: begin
          if (!ref_s[i]) begin
            state_nxt_s[i] = DT_OFF;
            dt_nxt_s[i]    = '0;
          end else begin
            state_nxt_s[i] = ON;
          end
        end
        DT_OFF: begin
          if (ref_s[i]) begin
            state_nxt_s[i] = ON;
          end else if (dt_r[i] == TW'(DEADTIME - 1)) begin
            state_nxt_s[i] = OFF;
          end else begin
            dt_nxt_s[i] = dt_r[i] + TW'(1);
          end
        end
        default: begin
          state_nxt_s[i] = IDLE;
        end
      endcase
    end
  end

  // Gate outputs decode from the single next state, so s and nots can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      nots <= '0;
      for (int i = 0; i < CH; i++) begin
        state_r[i] <= IDLE;
        dt_r[i]    <= '0;
      end
    end else if (!ce) begin
      s    <= '0;
      nots <= '0;
      for (int i = 0; i < CH; i++) begin
        state_r[i] <= IDLE;
        dt_r[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_r[i] <= state_nxt_s[i];
        dt_r[i]    <= dt_nxt_s[i];
        s[i]       <= (state_nxt_s[i] == ON);
        nots[i]    <= (state_nxt_s[i] == OFF);
      end
    end
  end

endmodule

// File: tb/tb_hb_pwm_dt_multi.sv
// Scoreboard bench for hb_pwm_dt_multi: a cycle model built from duty/dead-time
// rules pushes expected outputs each clock; a monitor pops and compares.
module tb_hb_pwm_dt_multi;
  localparam int CH = 2, DW = 10, PERIOD = 600, DEADTIME = 20, INT_DIV = 10, INT_HIGH = 5;

  logic             clk = 1'b0;
  logic             rst_n, ce;
  logic [CH*DW-1:0] d;
  logic [CH-1:0]    s, nots;
  logic             clk_int, period_start;

  hb_pwm_dt_multi #(.CH(CH), .DW(DW), .PERIOD(PERIOD), .DEADTIME(DEADTIME),
                    .INT_DIV(INT_DIV), .INT_HIGH(INT_HIGH)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .d(d), .s(s), .nots(nots),
    .clk_int(clk_int), .period_start(period_start));

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] s;
    logic [CH-1:0] nots;
    logic          ci;
    logic          ps;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model state: carrier position, loaded duties and per-channel history.
  int m_cnt, m_int, m_ps, m_started;
  int m_sh[CH];
  int hi_run[CH], lo_run[CH], side_high[CH];

  task automatic model_step();
    exp_t e;
    int   r[CH];
    e.s = '0; e.nots = '0; e.ci = 1'b0; e.ps = 1'b0;
    if (!rst_n || !ce) begin
      if (!rst_n) for (int c = 0; c < CH; c++) m_sh[c] = 0;
      m_cnt = 0; m_int = 0; m_ps = 0; m_started = 0;
    end else begin
      for (int c = 0; c < CH; c++) r[c] = (m_cnt < m_sh[c]) ? 1 : 0;
      if (m_ps != 0) m_int = (m_int + 1) % INT_DIV;
      e.ci = (m_int < INT_HIGH);
      m_ps = (m_cnt == PERIOD - 1) ? 1 : 0;
      e.ps = (m_ps != 0);
      if (m_cnt == 0)
        for (int c = 0; c < CH; c++) begin
          int dv;
          dv = int'(d[c*DW +: DW]);
          m_sh[c] = (dv > PERIOD) ? PERIOD : dv;
        end
      m_cnt = (m_cnt + 1) % PERIOD;
      for (int c = 0; c < CH; c++) begin
        if (m_started == 0) begin
          hi_run[c] = 0; lo_run[c] = 0; side_high[c] = 0;
          e.nots[c] = 1'b1;
        end else begin
          if (r[c] != 0) begin hi_run[c]++; lo_run[c] = 0; end
          else begin lo_run[c]++; hi_run[c] = 0; end
          // a side turns on only after DEADTIME+1 consecutive requests, unless it was the last side driven
          e.s[c]    = (r[c] != 0) && (side_high[c] != 0 || hi_run[c] > DEADTIME);
          e.nots[c] = (r[c] == 0) && (side_high[c] == 0 || lo_run[c] > DEADTIME);
          if (e.s[c]) side_high[c] = 1;
          else if (e.nots[c]) side_high[c] = 0;
          else side_high[c] = side_high[c];
        end
      end
      m_started = 1;
    end
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("no_overlap", int'(s & nots), 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("s", int'(s), int'(e.s));
        chk("nots", int'(nots), int'(e.nots));
        chk("clk_int", int'(clk_int), int'(e.ci));
        chk("period_start", int'(period_start), int'(e.ps));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_d(input int d0, input int d1);
    logic [DW-1:0] a, b;
    a = DW'(d0); b = DW'(d1);
    d = {b, a};
  endtask

  task automatic wait_ps(input string name);
    int k = 0;
    while (!period_start && k < 700) begin @(negedge clk); k++; end
    chk(name, (k < 700) ? 1 : 0, 1);
  endtask

  task automatic wait_s0(input string name);
    int k = 0;
    while (!s[0] && k < 1300) begin @(negedge clk); k++; end
    chk(name, (k < 1300) ? 1 : 0, 1);
  endtask

  initial begin
    int ns0, nn0, ns1, nlow1, nci, nps;
    rst_n = 1'b1; ce = 1'b0; d = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_s", int'(s), 0);
    chk("rst_async_nots", int'(nots), 0);
    chk("rst_async_ci", int'(clk_int), 0);
    cyc(3);
    rst_n = 1'b1; ce = 1'b1;
    cyc(1);
    chk("first_edge_nots", int'(nots), 3);
    chk("first_edge_s", int'(s), 0);
    cyc(700);

    // duty 300 on channel 0: 280 high, 280 low-side per period
    set_d(300, 0);
    cyc(1300);
    wait_ps("wait_ps_duty300");
    ns0 = 0; nn0 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      ns0 += int'(s[0]); nn0 += int'(nots[0]);
      @(negedge clk);
    end
    chk("duty300_s_high", ns0, 280);
    chk("duty300_nots_high", nn0, 280);

    // limits: saturating duty and a duty below the dead time
    set_d(1000, 10);
    cyc(1300);
    ns0 = 0; ns1 = 0; nlow1 = 0; nci = 0; nps = 0;
    for (int i = 0; i < 10 * PERIOD; i++) begin
      if (i < PERIOD) begin
        ns0 += int'(s[0]); ns1 += int'(s[1]); nlow1 += int'(!nots[1]);
      end
      nci += int'(clk_int); nps += int'(period_start);
      @(negedge clk);
    end
    chk("sat_s0_high", ns0, PERIOD);
    chk("short_s1_high", ns1, 0);
    chk("short_nots1_low", nlow1, 10);
    chk("int_high_cycles", nci, 3000);
    chk("ps_pulses", nps, 10);

    // mid-period update: scoreboard tracks the current and next period
    set_d(300, 300);
    cyc(1300);
    wait_ps("wait_ps_mid");
    cyc(150);
    set_d(100, 300);
    cyc(1300);

    // abort via ce while high side is on
    set_d(500, 200);
    cyc(700);
    wait_s0("wait_s0_ce");
    ce = 1'b0;
    cyc(1);
    chk("ce_abort_s", int'(s), 0);
    chk("ce_abort_nots", int'(nots), 0);
    cyc(3);
    ce = 1'b1;
    cyc(1);
    chk("ce_resume_nots", int'(nots), 3);
    cyc(1300);

    // async reset while high side is on
    wait_s0("wait_s0_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_s", int'(s), 0);
    chk("rst_mid_nots", int'(nots), 0);
    cyc(3);
    rst_n = 1'b1;
    cyc(1300);

    // randomized duties, update timing and ce glitches
    for (int it = 0; it < 16; it++) begin
      int sel0, sel1, v0, v1;
      sel0 = $urandom_range(0, 3); sel1 = $urandom_range(0, 3);
      v0 = (sel0 == 0) ? $urandom_range(0, 1023) : (sel0 == 1) ? $urandom_range(15, 25) :
           (sel0 == 2) ? $urandom_range(590, 610) : $urandom_range(0, 3);
      v1 = (sel1 == 0) ? $urandom_range(0, 1023) : (sel1 == 1) ? $urandom_range(15, 25) :
           (sel1 == 2) ? $urandom_range(590, 610) : $urandom_range(0, 3);
      set_d(v0, v1);
      cyc($urandom_range(200, 1500));
      if ($urandom_range(0, 3) == 0) begin
        ce = 1'b0;
        cyc($urandom_range(1, 5));
        ce = 1'b1;
      end
    end
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
